video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Source end of the core-to-video-pipeline interface.
- Generates the pixel clock enable, raster counters, blanking and active-low HSync/VSync for an arcade core.
- Registers the core's pixel colour into blanked R/G/B with syncs aligned to them.
- Outputs drive the video pipeline's R/G/B/HSync/VSync inputs directly and honour its ce_divider convention (clk_sys/4 or clk_sys/2).

Parameters:
- COLOR_DEPTH, 6, bits per colour channel (1-6).
- HCNT_WIDTH, 9, width of hcount.
- VCNT_WIDTH, 9, width of vcount.
- H_ACTIVE, 288, visible pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 32, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels; H_TOTAL = 384.
- V_ACTIVE, 224, visible lines.
- V_FP, 8, vertical front porch in lines.
- V_SYNC, 3, vsync width in lines.
- V_BP, 29, vertical back porch in lines; V_TOTAL = 264.

Ports:
- clk_sys  in  1  master clock.
- reset_n  in  1  asynchronous active-low reset.
- ce_divider  in  1  0 = ce_pix at clk_sys/4, 1 = ce_pix at clk_sys/2.
- r_in  in  COLOR_DEPTH  core pixel red for the current hcount/vcount.
- g_in  in  COLOR_DEPTH  core pixel green.
- b_in  in  COLOR_DEPTH  core pixel blue.
- ce_pix  out  1  one-clk_sys pixel enable.
- hcount  out  HCNT_WIDTH  fetch-stage pixel x.
- vcount  out  VCNT_WIDTH  fetch-stage line y.
- hblank  out  1  fetch-stage horizontal blank.
- vblank  out  1  fetch-stage vertical blank.
- R  out  COLOR_DEPTH  output-stage red.
- G  out  COLOR_DEPTH  output-stage green.
- B  out  COLOR_DEPTH  output-stage blue.
- HSync  out  1  active-low horizontal sync.
- VSync  out  1  active-low vertical sync.

Behaviour:
- Reset: div=0, ce_pix=0, hcount=0, vcount=0, hblank=0, vblank=0, R=G=B=0, HSync=1, VSync=1.
- Clock enable: 2-bit div increments every clk_sys.
  - ce_divider=0: ce_pix is registered high when div==3.
  - ce_divider=1: ce_pix is registered high when div[0]==1.
  - A ce_divider change takes effect next clk; at most one irregular pixel period; no double pulse.
- Fetch stage (all updates on the clk_sys edge where ce_pix=1):
  - hcount counts 0..H_TOTAL-1, then wraps to 0.
  - vcount increments when hcount wraps; vcount wraps at V_TOTAL-1 to 0.
  - hblank = (hcount >= H_ACTIVE); vblank = (vcount >= V_ACTIVE).
  - All four outputs change together, decoded from the next count value, so they are never inconsistent.
- Output stage: exactly one ce_pix after the fetch stage.
  - R/G/B = (hblank|vblank) ? 0 : r_in/g_in/b_in, sampled while the fetch stage shows that pixel.
  - HSync=0 for fetch hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - VSync=0 for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); VSync edges coincide with the HSync-delayed line start, i.e. the output-stage hcount==0.
  - Output-stage signals hold between ce_pix pulses.
- Latency: pixel (x,y) appears on R/G/B one ce_pix after hcount==x, vcount==y.
- Boundaries:
  - Last pixel of last line wraps both counters on the same ce_pix.
  - Reset assertion mid-line forces reset values immediately.
  - Deassertion restarts at pixel (0,0) with the first ce_pix on the 4th clk (/4) or 2nd clk (/2).
- Elaboration errors: H_TOTAL > 2^HCNT_WIDTH or V_TOTAL > 2^VCNT_WIDTH.

Optional Feature:
- Macro: VIDEO_OFFSET_EN.
- With it defined:
  - Adds ports h_offset in 4 and v_offset in 4, both signed two's complement.
  - The HSync window shifts by h_offset pixels and the VSync window by v_offset lines (modulo totals); blanking and counters are unchanged.
  - Offsets are sampled only at the ce_pix where the fetch stage wraps to (0,0), so there is no mid-frame tearing.
- Without it: ports absent, offsets fixed at 0.

Decomposition:
- Package video_timing_pkg: default timing constants, H_TOTAL/V_TOTAL and sync start/end localparam functions, the offset width constant.
- Sub-module pix_ce_gen: div counter and ce_pix generation; ports clk_sys, reset_n, ce_divider, ce_pix.

Test Plan:
- Reset release with ce_divider=0 → ce_pix every 4th clk; one line = 1536 clk; HSync low exactly 32 ce_pix (128 clk) starting at output-stage pixel 304.
- ce_divider=1 → line = 768 clk; frame = 264×384 ce_pix = 101376 ce_pix; VSync low for 3 lines beginning at line 232.
- r_in=g_in=b_in=hcount[5:0] → R at output pixel x equals x[5:0] for x<288; R=G=B=0 for x≥288 and for lines ≥224.
- Wrap: at hcount=383, vcount=263 → next ce_pix gives hcount=0, vcount=0, hblank=vblank=0 simultaneously.
- reset_n pulsed low mid-line 100 → all outputs at reset values in the same clk; counting restarts from (0,0).
- VIDEO_OFFSET_EN, h_offset=-2 written mid-frame → unchanged until the next frame; then HSync falls at pixel 302; v_offset=+1 → VSync starts at line 233.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared raster timing defaults and helpers for video_timing_gen.
// The optional sync trim (macro VIDEO_OFFSET_EN) uses OFS_W-bit signed offsets.
package video_timing_pkg;

    localparam int DEF_COLOR_DEPTH = 6;
    localparam int DEF_HCNT_WIDTH  = 9;
    localparam int DEF_VCNT_WIDTH  = 9;
    localparam int DEF_H_ACTIVE    = 288;
    localparam int DEF_H_FP        = 16;
    localparam int DEF_H_SYNC      = 32;
    localparam int DEF_H_BP        = 48;
    localparam int DEF_V_ACTIVE    = 224;
    localparam int DEF_V_FP        = 8;
    localparam int DEF_V_SYNC      = 3;
    localparam int DEF_V_BP        = 29;
    localparam int OFS_W           = 4;

    function automatic int frame_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/pix_ce_gen.sv
// Pixel clock enable: a free-running 2-bit divider yields a one-clk_sys pulse
// every 4th clock (ce_divider=0) or every 2nd clock (ce_divider=1).
module pix_ce_gen (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic ce_divider,
    output logic ce_pix
);

    logic [1:0] div_r;

    // Pulses only ever follow odd divider values, so a mode change cannot double-pulse.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_r  <= 2'd0;
            ce_pix <= 1'b0;
        end else begin
            div_r  <= div_r + 2'd1;
            ce_pix <= ce_divider ? div_r[0] : (div_r == 2'd3);
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: fetch-stage counters/blanking and output-stage blanked RGB with syncs.
// Define VIDEO_OFFSET_EN to add frame-synchronous h_offset/v_offset sync position trims.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int COLOR_DEPTH = DEF_COLOR_DEPTH,
    parameter int HCNT_WIDTH  = DEF_HCNT_WIDTH,
    parameter int VCNT_WIDTH  = DEF_VCNT_WIDTH,
    parameter int H_ACTIVE    = DEF_H_ACTIVE,
    parameter int H_FP        = DEF_H_FP,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BP        = DEF_H_BP,
    parameter int V_ACTIVE    = DEF_V_ACTIVE,
    parameter int V_FP        = DEF_V_FP,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BP        = DEF_V_BP
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce_divider,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    output logic                   ce_pix,
    output logic [HCNT_WIDTH-1:0]  hcount,
    output logic [VCNT_WIDTH-1:0]  vcount,
    output logic                   hblank,
    output logic                   vblank,
    output logic [COLOR_DEPTH-1:0] R,
    output logic [COLOR_DEPTH-1:0] G,
    output logic [COLOR_DEPTH-1:0] B,
    output logic                   HSync,
    output logic                   VSync
`ifdef VIDEO_OFFSET_EN
    ,
    input  logic signed [OFS_W-1:0] h_offset,
    input  logic signed [OFS_W-1:0] v_offset
`endif
);

    localparam int H_TOTAL  = frame_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = frame_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = sync_start(H_ACTIVE, H_FP);
    localparam int VS_START = sync_start(V_ACTIVE, V_FP);
    localparam int HRW      = HCNT_WIDTH + 2;
    localparam int VRW      = VCNT_WIDTH + 2;

    if (H_TOTAL > (1 << HCNT_WIDTH)) begin : g_h_width_chk
        $error("H_TOTAL does not fit in HCNT_WIDTH bits");
    end
    if (V_TOTAL > (1 << VCNT_WIDTH)) begin : g_v_width_chk
        $error("V_TOTAL does not fit in VCNT_WIDTH bits");
    end

    logic [HCNT_WIDTH-1:0]   h_next_s;
    logic [VCNT_WIDTH-1:0]   v_next_s;
    logic                    h_last_s;
    logic                    v_last_s;
    logic signed [OFS_W-1:0] h_off_s;
    logic signed [OFS_W-1:0] v_off_s;
    logic [HRW-1:0]          h_rel_s, h_m1_s, h_m2_s;
    logic [VRW-1:0]          v_rel_s, v_m1_s, v_m2_s;
    logic                    hs_act_s;
    logic                    vs_act_s;

    pix_ce_gen u_pix_ce_gen (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_divider (ce_divider),
        .ce_pix     (ce_pix)
    );

`ifdef VIDEO_OFFSET_EN
    logic signed [OFS_W-1:0] h_off_r;
    logic signed [OFS_W-1:0] v_off_r;

    // Offsets load only as the raster wraps to (0,0), so a frame is never torn.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            h_off_r <= '0;
            v_off_r <= '0;
        end else if (ce_pix && h_last_s && v_last_s) begin
            h_off_r <= h_offset;
            v_off_r <= v_offset;
        end
    end

    assign h_off_s = h_off_r;
    assign v_off_s = v_off_r;
`else
    assign h_off_s = '0;
    assign v_off_s = '0;
`endif

    // Next raster position; both counters wrap on the same pixel at the frame end.
    always_comb begin
        h_last_s = (hcount == HCNT_WIDTH'(H_TOTAL - 1));
        v_last_s = (vcount == VCNT_WIDTH'(V_TOTAL - 1));
        v_next_s = vcount;
        if (h_last_s) begin
            h_next_s = '0;
            if (v_last_s) begin
                v_next_s = '0;
            end else begin
                v_next_s = vcount + VCNT_WIDTH'(1);
            end
        end else begin
            h_next_s = hcount + HCNT_WIDTH'(1);
        end
    end

    // Sync windows as distance from the (offset) sync start, reduced modulo the line/frame total.
    always_comb begin
        h_rel_s  = HRW'(hcount) + HRW'(H_TOTAL - HS_START) - HRW'(h_off_s);
        h_m1_s   = (h_rel_s >= HRW'(H_TOTAL)) ? h_rel_s - HRW'(H_TOTAL) : h_rel_s;
        h_m2_s   = (h_m1_s >= HRW'(H_TOTAL)) ? h_m1_s - HRW'(H_TOTAL) : h_m1_s;
        hs_act_s = (h_m2_s < HRW'(H_SYNC));
        v_rel_s  = VRW'(vcount) + VRW'(V_TOTAL - VS_START) - VRW'(v_off_s);
        v_m1_s   = (v_rel_s >= VRW'(V_TOTAL)) ? v_rel_s - VRW'(V_TOTAL) : v_rel_s;
        v_m2_s   = (v_m1_s >= VRW'(V_TOTAL)) ? v_m1_s - VRW'(V_TOTAL) : v_m1_s;
        vs_act_s = (v_m2_s < VRW'(V_SYNC));
    end

    // Fetch stage advances the raster; output stage registers the pixel the fetch stage presented.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hcount <= '0;
            vcount <= '0;
            hblank <= 1'b0;
            vblank <= 1'b0;
            R      <= '0;
            G      <= '0;
            B      <= '0;
            HSync  <= 1'b1;
            VSync  <= 1'b1;
        end else if (ce_pix) begin
            hcount <= h_next_s;
            vcount <= v_next_s;
            hblank <= (h_next_s >= HCNT_WIDTH'(H_ACTIVE));
            vblank <= (v_next_s >= VCNT_WIDTH'(V_ACTIVE));
            R      <= (hblank || vblank) ? '0 : r_in;
            G      <= (hblank || vblank) ? '0 : g_in;
            B      <= (hblank || vblank) ? '0 : b_in;
            HSync  <= ~hs_act_s;
            VSync  <= ~vs_act_s;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen: pixel-index reference model plus directed timing pins.
// Vertical timing is shortened (40 lines) so whole frames fit in a short run.
module tb_video_timing_gen;

    localparam int CD    = 6;
    localparam int HA    = 288;
    localparam int HT    = 384;
    localparam int HSS   = 304;
    localparam int HSW   = 32;
    localparam int VA    = 24;
    localparam int VFP   = 8;
    localparam int VSW   = 3;
    localparam int VBP   = 5;
    localparam int VT    = VA + VFP + VSW + VBP;
    localparam int VSS   = VA + VFP;
    localparam int FRAME = HT * VT;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b1;
    logic          ce_divider = 1'b0;
    logic [CD-1:0] r_in = '0, g_in = '0, b_in = '0;
    logic          ce_pix, hblank, vblank, HSync, VSync;
    logic [8:0]    hcount, vcount;
    logic [CD-1:0] R, G, B;
    logic signed [3:0] h_offset = 4'sd0, v_offset = 4'sd0;

    int n_checks = 0;
    int n_fail   = 0;
    int k_rel    = 0;
    bit cmp_en   = 1'b0;

    int m_k = 0, m_p = 0;
    int m_hoff = 0, m_voff = 0, m_hoff_prev = 0, m_voff_prev = 0;

    video_timing_gen #(
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_divider (ce_divider),
        .r_in       (r_in),
        .g_in       (g_in),
        .b_in       (b_in),
        .ce_pix     (ce_pix),
        .hcount     (hcount),
        .vcount     (vcount),
        .hblank     (hblank),
        .vblank     (vblank),
        .R          (R),
        .G          (G),
        .B          (B),
        .HSync      (HSync),
        .VSync      (VSync)
`ifdef VIDEO_OFFSET_EN
        ,
        .h_offset   (h_offset),
        .v_offset   (v_offset)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit ce_rule(input int k, input bit mode);
        return mode ? (k >= 2 && k % 2 == 0) : (k >= 4 && k % 4 == 0);
    endfunction

    function automatic bit in_win(input int pos, input int start, input int off,
                                  input int width, input int total);
        int d;
        d = (pos - start - off) % total;
        if (d < 0) d += total;
        return d < width;
    endfunction

    // Reference: clocks since reset and number of pixels the raster has advanced.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            m_k <= 0; m_p <= 0;
            m_hoff <= 0; m_voff <= 0; m_hoff_prev <= 0; m_voff_prev <= 0;
        end else begin
            m_k <= m_k + 1;
            if (ce_rule(m_k, ce_divider)) begin
                m_p <= m_p + 1;
                if (m_p % FRAME == FRAME - 1) begin
                    m_hoff_prev <= m_hoff;
                    m_voff_prev <= m_voff;
`ifdef VIDEO_OFFSET_EN
                    m_hoff <= int'(h_offset);
                    m_voff <= int'(v_offset);
`endif
                end
            end
        end
    end

    // Every-cycle comparison against the reference, then present the next pixel colour.
    initial begin
        int fx, fy, q, ox, oy, ho, vo;
        bit vis;
        forever begin
            @(negedge clk_sys);
            fx = m_p % HT;
            fy = (m_p / HT) % VT;
            if (cmp_en) begin
                chk("ce_pix", ce_pix, reset_n && ce_rule(m_k, ce_divider));
                chk("hcount", hcount, fx);
                chk("vcount", vcount, fy);
                chk("hblank", hblank, fx >= HA);
                chk("vblank", vblank, fy >= VA);
                if (m_p == 0) begin
                    chk("R", R, 0); chk("G", G, 0); chk("B", B, 0);
                    chk("HSync", HSync, 1); chk("VSync", VSync, 1);
                end else begin
                    q   = m_p - 1;
                    ox  = q % HT;
                    oy  = (q / HT) % VT;
                    vis = (ox < HA) && (oy < VA);
                    ho  = (m_p % FRAME == 0) ? m_hoff_prev : m_hoff;
                    vo  = (m_p % FRAME == 0) ? m_voff_prev : m_voff;
                    chk("R", R, vis ? (ox % 64) : 0);
                    chk("G", G, vis ? (oy % 64) : 0);
                    chk("B", B, vis ? ((ox + oy) % 64) : 0);
                    chk("HSync", HSync, !in_win(ox, HSS, ho, HSW, HT));
                    chk("VSync", VSync, !in_win(oy, VSS, vo, VSW, VT));
                end
            end
            r_in = fx[5:0];
            g_in = fy[5:0];
            b_in = 6'((fx + fy) % 64);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
            k_rel++;
        end
    endtask

    task automatic release_rst();
        @(negedge clk_sys);
        #2;
        reset_n = 1'b1;
        k_rel   = 0;
    endtask

    task automatic wait_sync(input bit vert, input logic lvl, input int limit, output int n);
        n = 0;
        while (((vert ? VSync : HSync) !== lvl) && n < limit) begin
            step(1);
            n++;
        end
    endtask

    task automatic ce_switch(input bit mode, input int lo, input int hi);
        int dbl, pulses;
        logic prev;
        dbl = 0; pulses = 0; prev = ce_pix;
        @(negedge clk_sys);
        #2;
        ce_divider = mode;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_sys);
            #1;
            if (ce_pix && prev) dbl++;
            if (ce_pix) pulses++;
            prev = ce_pix;
        end
        chk("ce_switch_double", dbl, 0);
        chk("ce_switch_rate", (pulses >= lo) && (pulses <= hi), 1);
    endtask

    initial begin
        int n;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        cmp_en = 1'b1;
        #1;
        chk("rst_hcount", hcount, 0);
        chk("rst_hsync", HSync, 1);
        chk("rst_ce", ce_pix, 0);

        // Divide-by-4: colour latency and line timing.
        release_rst();
        step(45);
        chk("pix10_R", R, 10);
        chk("pix10_G", G, 0);
        chk("pix10_B", B, 10);
        wait_sync(1'b0, 1'b0, 3000, n);
        chk("hsync_first_fall_d4", k_rel, 1221);
        wait_sync(1'b0, 1'b1, 3000, n);
        chk("hsync_width_d4", n, 128);
        wait_sync(1'b0, 1'b0, 3000, n);
        chk("hsync_second_fall_d4", k_rel, 2757);

        // Mid-line asynchronous reset at pixel 100.
        n = 0;
        while ((m_p % HT) != 100 && n < 3000) begin
            step(1);
            n++;
        end
        chk("midline_hcount", hcount, 100);
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_hcount", hcount, 0);
        chk("async_rst_vcount", vcount, 0);
        chk("async_rst_R", R, 0);
        chk("async_rst_G", G, 0);
        chk("async_rst_ce", ce_pix, 0);
        chk("async_rst_hsync", HSync, 1);
        repeat (3) @(negedge clk_sys);
        release_rst();
        step(4);
        chk("restart_ce_4th", ce_pix, 1);
        chk("restart_hcount0", hcount, 0);
        step(1);
        chk("restart_hcount1", hcount, 1);
        step(1500);

        // Divide-by-2: line, frame, vsync and wrap.
        @(negedge clk_sys);
        #2 reset_n = 1'b0;
        ce_divider = 1'b1;
        release_rst();
        wait_sync(1'b0, 1'b0, 2000, n);
        chk("hsync_first_fall_d2", k_rel, 611);
        wait_sync(1'b0, 1'b1, 2000, n);
        chk("hsync_width_d2", n, 64);
        wait_sync(1'b0, 1'b0, 2000, n);
        chk("hsync_second_fall_d2", k_rel, 611 + 768);
        wait_sync(1'b1, 1'b0, 30000, n);
        chk("vsync_first_fall", k_rel, 24579);
        wait_sync(1'b1, 1'b1, 5000, n);
        chk("vsync_width", n, 2304);
        h_offset = -4'sd2;
        v_offset = 4'sd1;
        step(30719 - k_rel);
        chk("pre_wrap_hcount", hcount, 383);
        chk("pre_wrap_vcount", vcount, VT - 1);
        chk("pre_wrap_blank", {hblank, vblank}, 3);
        step(2);
        chk("wrap_hcount", hcount, 0);
        chk("wrap_vcount", vcount, 0);
        chk("wrap_blank", {hblank, vblank}, 0);
`ifdef VIDEO_OFFSET_EN
        wait_sync(1'b0, 1'b0, 2000, n);
        chk("hsync_offset_fall", k_rel, 31327);
        wait_sync(1'b1, 1'b0, 30000, n);
        chk("vsync_offset_fall", k_rel, 56067);
        wait_sync(1'b1, 1'b1, 5000, n);
        chk("vsync_offset_width", n, 2304);
`else
        step(1000);
`endif

        // Divider changes while running: no double pulse, new rate afterwards.
        cmp_en = 1'b0;
        ce_switch(1'b0, 9, 11);
        ce_switch(1'b1, 19, 21);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
